// File: rtl/div_seq_param.sv
// Multi-cycle radix-2 restoring divider for the HI/LO path: signed (DIV) and
// unsigned (DIVU) modes, quotient to lo, remainder to hi, div-by-zero flagged.
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a request sampled only in IDLE (no backpressure, it is
  // simply ignored while busy); busy is high from the accepting edge until the
  // result edge; done is a one-cycle pulse marking hi/lo/div_zero valid.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    count;
  logic             qneg;
  logic             rneg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             ge;

  // The shifted remainder carries one extra bit so divisors above 2^(WIDTH-1)
  // in unsigned mode compare correctly.
  always_comb begin
    shifted = {rem, dvd[count]};
    ge      = (shifted >= {1'b0, dvs});
    diff    = shifted[WIDTH-1:0] - dvs;
    a_mag   = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag   = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= a_mag;
            dvs      <= b_mag;
            qneg     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg     <= signed_op & a[WIDTH-1];
            rem      <= '0;
            quo      <= '0;
            count    <= CW'(WIDTH - 1);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= (b == '0) ? ZERO : CALC;
          end
        end
        CALC: begin
          rem        <= ge ? diff : shifted[WIDTH-1:0];
          quo[count] <= ge;
          if (count == '0) state <= FIX;
          else count <= count - CW'(1);
        end
        FIX: begin
          lo    <= qneg ? -quo : quo;
          hi    <= rneg ? -rem : rem;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ZERO: begin
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: a 32-bit instance for directed cases and
// an 8-bit instance swept against a magnitude-based reference model.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start = 1'b0, signed_op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [1:0]  fsm_state;

  logic        start8 = 1'b0, signed8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic [1:0]  st8;

  int checks = 0;
  int fails  = 0;

  logic [63:0] exp_q[$];
  logic        exp_dz_q[$];
  logic [15:0] exp8_q[$];
  logic [31:0] last_hi = '0, last_lo = '0;

  div_seq_param #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo), .fsm_state(fsm_state)
  );

  div_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(signed8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8), .fsm_state(st8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: divide magnitudes, then apply truncate-toward-zero signs. Returns {hi, lo}.
  function automatic logic [63:0] model(input int w, input logic s, input logic [31:0] av,
                                        input logic [31:0] bv);
    logic [31:0] mask, ma, mb, q, r, lo_v, hi_v;
    logic sa, sb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sa   = s & av[w-1];
    sb   = s & bv[w-1];
    ma   = sa ? ((-av) & mask) : (av & mask);
    mb   = sb ? ((-bv) & mask) : (bv & mask);
    q    = ma / mb;
    r    = ma % mb;
    lo_v = (sa ^ sb) ? ((-q) & mask) : q;
    hi_v = sa ? ((-r) & mask) : r;
    return {hi_v, lo_v};
  endfunction

  // Drivers: entered and left at a negedge. Pushes expectations, pulses start,
  // scrambles the operands after the accepting edge, waits (bounded) for done.
  task automatic drive_op32(input logic s, input logic [31:0] av, input logic [31:0] bv,
                            output int lat);
    logic [63:0] m;
    if (bv == 32'd0) begin
      exp_q.push_back({last_hi, last_lo});
      exp_dz_q.push_back(1'b1);
    end else begin
      m = model(32, s, av, bv);
      exp_q.push_back(m);
      exp_dz_q.push_back(1'b0);
      last_hi = m[63:32];
      last_lo = m[31:0];
    end
    start = 1'b1; signed_op = s; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_op = 1'($urandom_range(0, 1));
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic drive_op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                           output int lat);
    logic [63:0] m;
    m = model(8, s, {24'd0, av}, {24'd0, bv});
    exp8_q.push_back({m[39:32], m[7:0]});
    start8 = 1'b1; signed8 = s; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (done8) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      fails++; $display("FAIL reset_held: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                        busy, done, div_zero, hi, lo);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, hi, lo, fsm_state} !== 69'd0) begin
      fails++; $display("FAIL reset_release: got busy=%b done=%b dz=%b hi=%h lo=%h st=%0d want 0",
                        busy, done, div_zero, hi, lo, fsm_state);
    end
    checks++;
    if ({busy8, done8, dz8, hi8, lo8} !== 19'd0) begin
      fails++; $display("FAIL reset_w8: got busy=%b done=%b dz=%b hi=%h lo=%h want 0",
                        busy8, done8, dz8, hi8, lo8);
    end
  endtask

  task automatic test_signed();
    logic [31:0] av[3] = '{32'd100, 32'hFFFF_FF9C, 32'd100};
    logic [31:0] bv[3] = '{32'd7, 32'd7, 32'hFFFF_FFF9};
    logic [63:0] e;
    logic ez;
    int lat;
    for (int i = 0; i < 3; i++) begin
      drive_op32(1'b1, av[i], bv[i], lat);
      e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
      checks++;
      if (lat !== 33) begin fails++; $display("FAIL signed_lat[%0d]: got %0d want 33", i, lat); end
      checks++;
      if ({hi, lo} !== e) begin
        fails++; $display("FAIL signed_res[%0d]: got hi=%h lo=%h want hi=%h lo=%h",
                          i, hi, lo, e[63:32], e[31:0]);
      end
      checks++;
      if (div_zero !== ez || busy !== 1'b0) begin
        fails++; $display("FAIL signed_flags[%0d]: got dz=%b busy=%b want dz=%b busy=0",
                          i, div_zero, busy, ez);
      end
    end
  endtask

  task automatic test_wrap_and_unsigned();
    logic        sv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] av[4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bv[4] = '{32'd2, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF};
    logic [63:0] e;
    logic ez;
    int lat;
    for (int i = 0; i < 4; i++) begin
      drive_op32(sv[i], av[i], bv[i], lat);
      e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
      checks++;
      if (lat !== 33 || div_zero !== ez) begin
        fails++; $display("FAIL wrap_lat[%0d]: got lat=%0d dz=%b want 33/%b", i, lat, div_zero, ez);
      end
      checks++;
      if ({hi, lo} !== e) begin
        fails++; $display("FAIL wrap_res[%0d]: got hi=%h lo=%h want hi=%h lo=%h",
                          i, hi, lo, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] e;
    logic ez;
    int lat;
    drive_op32(1'b0, 32'd26, 32'd7, lat);   // leaves hi=5, lo=3
    e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      fails++; $display("FAIL dz_preload: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
    end
    drive_op32(1'b1, 32'd123, 32'd0, lat);
    e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL dz_lat: got %0d want 1", lat); end
    checks++;
    if (div_zero !== ez || busy !== 1'b0) begin
      fails++; $display("FAIL dz_flag: got dz=%b busy=%b want dz=%b busy=0", div_zero, busy, ez);
    end
    checks++;
    if ({hi, lo} !== e) begin
      fails++; $display("FAIL dz_hold: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b1) begin
      fails++; $display("FAIL dz_pulse: got done=%b dz=%b want done=0 dz=1", done, div_zero);
    end
    drive_op32(1'b0, 32'd50, 32'd6, lat);
    e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
    checks++;
    if (div_zero !== ez || {hi, lo} !== e || lat !== 33) begin
      fails++; $display("FAIL dz_clear: got dz=%b hi=%h lo=%h lat=%0d want dz=%b hi=%h lo=%h lat=33",
                        div_zero, hi, lo, lat, ez, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_ignore_start();
    logic [63:0] e, prev, m;
    logic ez;
    int lat;
    prev = {last_hi, last_lo};
    m = model(32, 1'b1, 32'hFFFF_FC18, 32'd13);
    exp_q.push_back(m); exp_dz_q.push_back(1'b0);
    last_hi = m[63:32]; last_lo = m[31:0];
    start = 1'b1; signed_op = 1'b1; a = 32'hFFFF_FC18; b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin lat = c; break; end
      if (c == 10) begin
        start = 1'b1; signed_op = 1'b0; a = 32'd5; b = 32'd1;
        checks++;
        if ({hi, lo} !== prev || busy !== 1'b1) begin
          fails++; $display("FAIL busy_hold: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=1",
                            hi, lo, busy, prev[63:32], prev[31:0]);
        end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
    checks++;
    if (lat !== 33) begin fails++; $display("FAIL ignore_lat: got %0d want 33", lat); end
    checks++;
    if ({hi, lo} !== e || div_zero !== ez) begin
      fails++; $display("FAIL ignore_res: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                        hi, lo, div_zero, e[63:32], e[31:0], ez);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] e;
    logic ez;
    int lat;
    start = 1'b1; signed_op = 1'b0; a = 32'd999; b = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero, hi, lo, fsm_state} !== 69'd0) begin
      fails++; $display("FAIL reset_mid: got busy=%b done=%b dz=%b hi=%h lo=%h st=%0d want 0",
                        busy, done, div_zero, hi, lo, fsm_state);
    end
    last_hi = '0; last_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_op32(1'b1, 32'hFFFF_FF00, 32'd9, lat);
    e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
    checks++;
    if ({hi, lo} !== e || lat !== 33 || div_zero !== ez) begin
      fails++; $display("FAIL reset_fresh: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=33",
                        hi, lo, lat, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic ez;
    int lat;
    for (int i = 0; i < 8; i++) begin
      drive_op32(1'($urandom_range(0, 1)), $urandom, (i == 3) ? 32'd0 : 32'($urandom_range(1, 65535)), lat);
      e = exp_q.pop_front(); ez = exp_dz_q.pop_front();
      checks++;
      if (lat !== (ez ? 1 : 33) || {hi, lo} !== e || div_zero !== ez) begin
        fails++; $display("FAIL b2b[%0d]: got lat=%0d dz=%b hi=%h lo=%h want lat=%0d dz=%b hi=%h lo=%h",
                          i, lat, div_zero, hi, lo, ez ? 1 : 33, ez, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_w8_sweep();
    logic [15:0] e;
    logic [7:0]  bsel[6];
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 256; av++) begin
        bsel = '{8'd1, 8'd3, 8'h7F, 8'h80, 8'hFF, 8'($urandom_range(1, 255))};
        for (int j = 0; j < 6; j++) begin
          drive_op8(1'(s), 8'(av), bsel[j], lat);
          e = exp8_q.pop_front();
          checks++;
          if ({hi8, lo8} !== e || lat !== 9 || dz8 !== 1'b0) begin
            fails++; $display("FAIL w8 s=%0d a=%h b=%h: got hi=%h lo=%h lat=%0d dz=%b want hi=%h lo=%h lat=9",
                              s, av, bsel[j], hi8, lo8, lat, dz8, e[15:8], e[7:0]);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin fails++; $display("FAIL w8_pulse: got done=%b want 0", done8); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_wrap_and_unsigned();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    test_w8_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
